clause_feeder: RTL

- Writer-side counterpart to the clause register.
- Holds up to MAX_CLAUSES packed clause-coefficient words in local storage.
- Sequences through the stored words, presenting one at a time on the coefficient bus with a one-cycle write-enable pulse.
- Waits for the evaluator to report completion before issuing the next clause; supports single-sweep and continuous sweeps.

---
 rtl/clause_feeder_if.sv | 47 ++++
 rtl/clause_feeder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/clause_feeder_if.sv
// Clause feeder bundle: storage load port, sweep controls and the clause issue bus.
// out_sweep_count exists only when CLAUSE_FEEDER_SWEEP_COUNTER_EN is defined.
interface clause_feeder_if #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned NUM_VARS  = 4,
  parameter int unsigned IDX_WIDTH = 4
);
  localparam int unsigned W = BIT_WIDTH * NUM_VARS;

  logic               in_load_valid;
  logic [W-1:0]       in_load_clause;
  logic               out_load_ready;
  logic               in_clear;
  logic               in_start;
  logic               in_continuous;
  logic               in_stop;
  logic               in_clause_done;
  logic [W-1:0]       out_clause_coefficients;
  logic               out_write_enable;
  logic [IDX_WIDTH:0] out_clause_index;
  logic [IDX_WIDTH:0] out_clause_count;
  logic               out_sweep_done;
  logic               out_busy;
`ifdef CLAUSE_FEEDER_SWEEP_COUNTER_EN
  logic [15:0]        out_sweep_count;
`endif

  modport master (
    output in_load_valid, in_load_clause, in_clear, in_start, in_continuous, in_stop,
           in_clause_done,
    input  out_load_ready, out_clause_coefficients, out_write_enable, out_clause_index,
           out_clause_count, out_sweep_done, out_busy
`ifdef CLAUSE_FEEDER_SWEEP_COUNTER_EN
    , input out_sweep_count
`endif
  );

  modport slave (
    input  in_load_valid, in_load_clause, in_clear, in_start, in_continuous, in_stop,
           in_clause_done,
    output out_load_ready, out_clause_coefficients, out_write_enable, out_clause_index,
           out_clause_count, out_sweep_done, out_busy
`ifdef CLAUSE_FEEDER_SWEEP_COUNTER_EN
    , output out_sweep_count
`endif
  );
endinterface

// File: rtl/clause_feeder.sv
// Stores clause words and issues them one at a time, waiting for the evaluator between issues.
// Optional saturating sweep counter enabled by CLAUSE_FEEDER_SWEEP_COUNTER_EN.
module clause_feeder #(
  parameter int unsigned BIT_WIDTH   = 16,
  parameter int unsigned NUM_VARS    = 4,
  parameter int unsigned MAX_CLAUSES = 16,
  parameter int unsigned IDX_WIDTH   = 4
) (
  input logic            in_clk,
  input logic            in_reset,
  clause_feeder_if.slave bus
);
  localparam int unsigned W    = BIT_WIDTH * NUM_VARS;
  localparam int unsigned CntW = IDX_WIDTH + 1;
  localparam logic [CntW-1:0] MaxCount = CntW'(MAX_CLAUSES);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone
  } state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_count, w_count_d;
  logic [CntW-1:0] r_index, w_index_d;
  logic            r_continuous, w_continuous_d;
  logic [W-1:0]    r_coeff, w_coeff_d;
  logic            r_write_enable, w_write_enable_d;
  logic            r_sweep_done, w_sweep_done_d;
  logic            r_load_ready, w_load_ready_d;
  logic            r_busy, w_busy_d;
  logic            w_mem_write;
  logic            w_clear_take;
  logic            w_last;

  logic [W-1:0]    r_mem [MAX_CLAUSES];

  assign w_last = (r_index == (r_count - CntW'(1)));

  always_comb begin
    w_state_d        = r_state;
    w_count_d        = r_count;
    w_index_d        = r_index;
    w_continuous_d   = r_continuous;
    w_write_enable_d = 1'b0;
    w_sweep_done_d   = 1'b0;
    w_mem_write      = 1'b0;
    w_clear_take     = 1'b0;

    unique case (r_state)
      StIdle: begin
        // Start outranks clear and load; a start with nothing stored is a no-op.
        if (bus.in_start) begin
          if (r_count != '0) begin
            w_state_d        = StIssue;
            w_continuous_d   = bus.in_continuous;
            w_index_d        = '0;
            w_write_enable_d = 1'b1;
          end
        end else if (bus.in_clear) begin
          w_clear_take = 1'b1;
          w_count_d    = '0;
        end else if (bus.in_load_valid && r_load_ready) begin
          w_mem_write = 1'b1;
          w_count_d   = r_count + CntW'(1);
        end
      end

      StIssue: begin
        w_index_d = r_index;
        if (bus.in_stop) begin
          w_state_d = StIdle;
          w_index_d = '0;
        end else begin
          w_state_d = StWaitDone;
        end
      end

      StWaitDone: begin
        if (bus.in_stop) begin
          w_state_d = StIdle;
          w_index_d = '0;
        end else if (bus.in_clause_done) begin
          if (w_last) begin
            w_sweep_done_d = 1'b1;
            w_index_d      = '0;
            if (r_continuous) begin
              w_state_d        = StIssue;
              w_write_enable_d = 1'b1;
            end else begin
              w_state_d = StIdle;
            end
          end else begin
            w_index_d        = r_index + CntW'(1);
            w_state_d        = StIssue;
            w_write_enable_d = 1'b1;
          end
        end
      end

      default: begin
        w_state_d = StIdle;
        w_index_d = '0;
      end
    endcase

    // The coefficient register only changes on an issue, so it holds through WAIT_DONE.
    w_coeff_d      = w_write_enable_d ? r_mem[w_index_d[IDX_WIDTH-1:0]] : r_coeff;
    w_busy_d       = (w_state_d != StIdle);
    w_load_ready_d = (w_state_d == StIdle) && (w_count_d < MaxCount);
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      r_state        <= StIdle;
      r_count        <= '0;
      r_index        <= '0;
      r_continuous   <= 1'b0;
      r_coeff        <= '0;
      r_write_enable <= 1'b0;
      r_sweep_done   <= 1'b0;
      r_load_ready   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_count        <= w_count_d;
      r_index        <= w_index_d;
      r_continuous   <= w_continuous_d;
      r_coeff        <= w_coeff_d;
      r_write_enable <= w_write_enable_d;
      r_sweep_done   <= w_sweep_done_d;
      r_load_ready   <= w_load_ready_d;
      r_busy         <= w_busy_d;
    end
  end

  // Clause storage keeps its contents across reset; only the count is cleared.
  always_ff @(posedge in_clk) begin
    if (w_mem_write) begin
      r_mem[r_count[IDX_WIDTH-1:0]] <= bus.in_load_clause;
    end
  end

  assign bus.out_load_ready          = r_load_ready;
  assign bus.out_clause_coefficients = r_coeff;
  assign bus.out_write_enable        = r_write_enable;
  assign bus.out_clause_index        = r_index;
  assign bus.out_clause_count        = r_count;
  assign bus.out_sweep_done          = r_sweep_done;
  assign bus.out_busy                = r_busy;

`ifdef CLAUSE_FEEDER_SWEEP_COUNTER_EN
  logic [15:0] r_sweep_count;

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      r_sweep_count <= '0;
    end else if (w_clear_take) begin
      r_sweep_count <= '0;
    end else if (w_sweep_done_d && (r_sweep_count != 16'hFFFF)) begin
      r_sweep_count <= r_sweep_count + 16'd1;
    end
  end

  assign bus.out_sweep_count = r_sweep_count;
`endif

endmodule
